mac_sequencer: RTL and testbench
================================

MAC_SEQUENCER -- requirements
Module: mac_sequencer

Interface
REQ-001 SHALL have parameter WIDTH_CNT, default 5; width of job length and step index.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 255; stall limit in cycles, used only with MAC_SEQ_TIMEOUT_EN.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 start_i  input  1  job request, sampled in IDLE only.
REQ-006 len_i  input  WIDTH_CNT  job length in steps, latched with start_i.
REQ-007 step_valid_o  output  1  step offered to the MAC datapath.
REQ-008 step_ready_i  input  1  datapath accepts the offered step.
REQ-009 step_idx_o  output  WIDTH_CNT  index of the offered step, 0..len-1.
REQ-010 cnt_en_o  output  1  enable to the step counter; high on each accepted step.
REQ-011 cnt_clr_o  output  1  one-cycle clear to the step counter at job start.
REQ-012 busy_o  output  1  high from job start until the DONE cycle inclusive.
REQ-013 done_o  output  1  one-cycle completion pulse.
REQ-014 irq_o  output  1  sticky completion interrupt.
REQ-015 irq_ack_i  input  1  clears irq_o.
REQ-016 err_o  output  1  sticky timeout flag; present only with MAC_SEQ_TIMEOUT_EN.

Function
REQ-017 SHALL implement the FSM states IDLE, CLR, RUN and DONE.
REQ-018 IDLE: on start_i=1, SHALL latch len_i and go to CLR; with start_i=0, SHALL stay in IDLE.
REQ-019 CLR: SHALL assert cnt_clr_o for exactly one cycle and zero the index; then go to RUN if latched len!=0, else go to DONE.
REQ-020 RUN: SHALL hold step_valid_o=1 with step_idx_o stable until handshake (step_valid_o && step_ready_i).
REQ-021 SHALL drive cnt_en_o combinationally equal to the handshake; no extra latency.
REQ-022 On handshake with idx<len-1, SHALL increment idx by 1 next cycle.
REQ-023 On handshake with idx==len-1, SHALL deassert step_valid_o next cycle and go to DONE.
REQ-024 DONE: SHALL assert done_o for one cycle, set irq_o, then return to IDLE.
REQ-025 SHALL ignore start_i outside IDLE, including in the DONE cycle.
REQ-026 Back-to-back job: start_i high in the first IDLE cycle after DONE SHALL be accepted, giving a 1-cycle IDLE gap.
REQ-027 Index SHALL never wrap: len=2^WIDTH_CNT-1 ends at idx=2^WIDTH_CNT-2.
REQ-028 If irq set and irq_ack_i occur in the same cycle, set SHALL win.
REQ-029 busy_o SHALL be 1 in CLR, RUN and DONE, and 0 in IDLE.

Reset
REQ-030 When rst_n=0 at a clock edge, SHALL enter IDLE from any state, including mid-job, and discard the latched len and idx.
REQ-031 Reset values SHALL be 0 for all of: step_valid_o, step_idx_o, cnt_en_o, cnt_clr_o, busy_o, done_o, irq_o, err_o.

Configuration
REQ-032 Macro MAC_SEQ_TIMEOUT_EN SHALL gate the stall watchdog.
REQ-033 With MAC_SEQ_TIMEOUT_EN defined, stall cycles SHALL be counted in RUN while step_valid_o=1 and step_ready_i=0, and cleared on handshake.
REQ-034 With MAC_SEQ_TIMEOUT_EN defined, reaching TIMEOUT_CYC stall cycles SHALL abort to DONE and set err_o; err_o SHALL be cleared by irq_ack_i.
REQ-035 Without MAC_SEQ_TIMEOUT_EN, there SHALL be no err_o port and no watchdog logic, and RUN SHALL wait indefinitely.

Structure
REQ-036 Package mac_pkg SHALL hold the FSM state enum typedef and the default constants for WIDTH_CNT and TIMEOUT_CYC.
REQ-037 The watchdog SHALL be a sub-module mac_seq_watchdog (inputs: stall, clear; output: expired), instantiated only under MAC_SEQ_TIMEOUT_EN.

Verification
REQ-038 Job len=3 with step_ready_i=1 constant -> idx 0,1,2 on consecutive cycles, 3 cnt_en_o pulses, done_o 1 cycle after last handshake, irq_o=1.
REQ-039 Job len=2 with step_ready_i low for 4 cycles on idx 0 -> idx held at 0 and cnt_en_o=0 throughout, then 2 handshakes, done_o.
REQ-040 Job len=0 -> CLR then DONE, no step_valid_o, done_o 2 cycles after start.
REQ-041 start_i pulsed during RUN and during DONE -> ignored; next start in IDLE accepted; irq_ack_i together with done -> irq_o stays 1.
REQ-042 rst_n low at idx=2 of a len=5 job -> next cycle IDLE, all outputs 0; new len=1 job completes normally.
REQ-043 With MAC_SEQ_TIMEOUT_EN and TIMEOUT_CYC=8, step_ready_i held 0 -> abort to DONE after 8 stall cycles, err_o=1; irq_ack_i clears err_o and irq_o.

Source files
------------

// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared types and default constants for the MAC step sequencer
//
// Purpose : FSM state encoding and the default parameter values used by
//           mac_sequencer and mac_seq_watchdog.
// Contents: mac_state_e, MAC_WIDTH_CNT_DEF, MAC_TIMEOUT_CYC_DEF
package mac_pkg;

  localparam int MAC_WIDTH_CNT_DEF   = 5;
  localparam int MAC_TIMEOUT_CYC_DEF = 255;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CLR  = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } mac_state_e;

endpackage

// File: rtl/mac_seq_watchdog.sv
// rtl/mac_seq_watchdog.sv - stall-cycle watchdog for the MAC step sequencer
//
// Purpose : counts consecutive stall cycles and flags expiry on the
//           TIMEOUT_CYC-th one.
// Ports   : clk, rst_n   clock, synchronous active-low reset
//           stall        step offered but not accepted this cycle
//           clear        restart the count (handshake or not running)
//           expired      high during the stall cycle that reaches TIMEOUT_CYC
module mac_seq_watchdog
  import mac_pkg::*;
#(
  parameter int TIMEOUT_CYC = MAC_TIMEOUT_CYC_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic stall,
  input  logic clear,
  output logic expired
);

  // The counter only needs to reach TIMEOUT_CYC-1; expiry is decoded on the
  // stall cycle that would make it TIMEOUT_CYC.
  localparam int CW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);

  logic [CW-1:0] cnt;

  assign expired = stall && (cnt == CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (stall && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mac_sequencer.sv
// rtl/mac_sequencer.sv - step sequencer driving a MAC datapath through one job
//
// Purpose : accepts a job of len steps, clears the step counter, offers steps
//           0..len-1 with a valid/ready handshake, then pulses done and sets
//           a sticky interrupt.
// Build   : define MAC_SEQ_TIMEOUT_EN to add the stall watchdog and err_o.
// Ports   : clk, rst_n          clock, synchronous active-low reset
//           start_i, len_i      job request and length (sampled in IDLE)
//           step_valid_o/_ready_i, step_idx_o  step handshake and index
//           cnt_en_o, cnt_clr_o step counter enable / clear
//           busy_o, done_o      job activity and completion pulse
//           irq_o, irq_ack_i    sticky completion interrupt and its clear
//           err_o               sticky timeout flag (MAC_SEQ_TIMEOUT_EN only)
module mac_sequencer
  import mac_pkg::*;
#(
  parameter int WIDTH_CNT   = MAC_WIDTH_CNT_DEF,
  parameter int TIMEOUT_CYC = MAC_TIMEOUT_CYC_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic [WIDTH_CNT-1:0] len_i,
  output logic                 step_valid_o,
  input  logic                 step_ready_i,
  output logic [WIDTH_CNT-1:0] step_idx_o,
  output logic                 cnt_en_o,
  output logic                 cnt_clr_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 irq_o,
`ifdef MAC_SEQ_TIMEOUT_EN
  output logic                 err_o,
`endif
  input  logic                 irq_ack_i
);

  mac_state_e           state, state_nxt;
  logic [WIDTH_CNT-1:0] len_q;
  logic [WIDTH_CNT-1:0] idx_q;
  logic                 irq_q;
  logic                 last_step;
  logic                 abort;

  assign step_valid_o = (state == ST_RUN);
  assign step_idx_o   = step_valid_o ? idx_q : '0;
  assign cnt_en_o     = step_valid_o && step_ready_i;
  assign cnt_clr_o    = (state == ST_CLR);
  assign busy_o       = (state != ST_IDLE);
  assign done_o       = (state == ST_DONE);
  assign irq_o        = irq_q;

  // len_q is non-zero whenever RUN is entered, so len_q-1 cannot underflow here.
  assign last_step = (idx_q == len_q - WIDTH_CNT'(1));

`ifdef MAC_SEQ_TIMEOUT_EN
  logic err_q;
  logic wd_stall;
  logic wd_clear;

  assign wd_stall = step_valid_o && !step_ready_i;
  assign wd_clear = !step_valid_o || cnt_en_o;
  assign err_o    = err_q;

  mac_seq_watchdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .stall  (wd_stall),
    .clear  (wd_clear),
    .expired(abort)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (abort) begin
      err_q <= 1'b1;
    end else if (irq_ack_i) begin
      err_q <= 1'b0;
    end
  end
`else
  logic unused_timeout;

  assign abort          = 1'b0;
  assign unused_timeout = (TIMEOUT_CYC != 0);
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start_i) state_nxt = ST_CLR;
      ST_CLR:  state_nxt = (len_q != '0) ? ST_RUN : ST_DONE;
      ST_RUN:  if ((cnt_en_o && last_step) || abort) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      len_q <= '0;
      idx_q <= '0;
      irq_q <= 1'b0;
    end else begin
      state <= state_nxt;

      if (state == ST_IDLE && start_i) begin
        len_q <= len_i;
      end

      // The index stops at len-1 on the final handshake, so it never wraps.
      if (state == ST_CLR) begin
        idx_q <= '0;
      end else if (cnt_en_o && !last_step) begin
        idx_q <= idx_q + WIDTH_CNT'(1);
      end

      // Setting in DONE takes priority over a simultaneous acknowledge.
      if (state == ST_DONE) begin
        irq_q <= 1'b1;
      end else if (irq_ack_i) begin
        irq_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mac_sequencer.sv
// tb/tb_mac_sequencer.sv - self-checking bench for mac_sequencer
module tb_mac_sequencer;

  localparam int W = 5;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_i;
  logic [W-1:0] len_i;
  logic         step_valid_o;
  logic         step_ready_i;
  logic [W-1:0] step_idx_o;
  logic         cnt_en_o;
  logic         cnt_clr_o;
  logic         busy_o;
  logic         done_o;
  logic         irq_o;
  logic         irq_ack_i;
`ifdef MAC_SEQ_TIMEOUT_EN
  logic         err_o;
`endif

  always #5 clk = ~clk;

  mac_sequencer #(
    .WIDTH_CNT  (W),
    .TIMEOUT_CYC(8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .len_i       (len_i),
    .step_valid_o(step_valid_o),
    .step_ready_i(step_ready_i),
    .step_idx_o  (step_idx_o),
    .cnt_en_o    (cnt_en_o),
    .cnt_clr_o   (cnt_clr_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .irq_o       (irq_o),
`ifdef MAC_SEQ_TIMEOUT_EN
    .err_o       (err_o),
`endif
    .irq_ack_i   (irq_ack_i)
  );

  int total = 0;
  int bad   = 0;
  int exp_q[$];
  int sb_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, want, $time);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Scoreboard: every accepted step must match the next expected index.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && cnt_en_o === 1'b1) begin
      chk("en_needs_valid", step_valid_o, 1'b1);
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_step", 32'd1, 32'd0);
      end else begin
        sb_e = exp_q.pop_front();
        chk("sb_idx", step_idx_o, sb_e);
      end
    end
  end

  typedef struct {
    int len;
    int stall_idx;
    int stall_n;
    int done_k;    // cycle of done_o counted from the start cycle (0)
  } job_t;

  job_t jobs[7];

  // Runs one job from IDLE; returns one cycle into IDLE after irq is acked.
  task automatic run_job(input job_t j);
    int  k, en_n, clr_n, done_k;
    bit  stall;
    for (int i = 0; i < j.len; i++) exp_q.push_back(i);
    start_i = 1'b1;
    len_i   = W'(j.len);
    k = 0; en_n = 0; clr_n = 0; done_k = -1;
    while (k < 200 && done_k < 0) begin
      stall = (k >= 2 + j.stall_idx) && (k < 2 + j.stall_idx + j.stall_n);
      step_ready_i = !stall;
      smp();
      if (cnt_en_o) en_n++;
      if (cnt_clr_o) clr_n++;
      if (stall && j.len > 0) begin
        chk("stall_idx_held", step_idx_o, j.stall_idx);
        chk("stall_no_en", cnt_en_o, 1'b0);
      end
      if (j.len == 0) chk("len0_no_valid", step_valid_o, 1'b0);
      if (done_o) done_k = k;
      nxt();
      start_i = 1'b0;
      k++;
    end
    step_ready_i = 1'b1;
    chk("done_latency", done_k, j.done_k);
    chk("en_pulses", en_n, j.len);
    chk("clr_pulses", clr_n, 1);
    chk("sb_drained", exp_q.size(), 0);
    irq_ack_i = 1'b1;
    smp();
    chk("irq_set", irq_o, 1'b1);
    chk("idle_not_busy", busy_o, 1'b0);
    chk("done_one_cycle", done_o, 1'b0);
    nxt();
    irq_ack_i = 1'b0;
    smp();
    chk("irq_acked", irq_o, 1'b0);
    nxt();
  endtask

  task automatic all_zero(input string name);
    chk({name, "_valid"}, step_valid_o, 1'b0);
    chk({name, "_idx"}, step_idx_o, 0);
    chk({name, "_en"}, cnt_en_o, 1'b0);
    chk({name, "_clr"}, cnt_clr_o, 1'b0);
    chk({name, "_busy"}, busy_o, 1'b0);
    chk({name, "_done"}, done_o, 1'b0);
    chk({name, "_irq"}, irq_o, 1'b0);
`ifdef MAC_SEQ_TIMEOUT_EN
    chk({name, "_err"}, err_o, 1'b0);
`endif
  endtask

  int k;

  initial begin
    jobs[0] = '{len: 3,  stall_idx: 0,  stall_n: 0, done_k: 5};
    jobs[1] = '{len: 2,  stall_idx: 0,  stall_n: 4, done_k: 8};
    jobs[2] = '{len: 0,  stall_idx: 0,  stall_n: 0, done_k: 2};
    jobs[3] = '{len: 1,  stall_idx: 0,  stall_n: 0, done_k: 3};
    jobs[4] = '{len: 31, stall_idx: 0,  stall_n: 0, done_k: 33};
    jobs[5] = '{len: 4,  stall_idx: 2,  stall_n: 3, done_k: 9};
    jobs[6] = '{len: 31, stall_idx: 30, stall_n: 2, done_k: 35};

    rst_n = 1'b0; start_i = 1'b1; len_i = W'(7); step_ready_i = 1'b1; irq_ack_i = 1'b0;
    nxt(); nxt(); nxt();
    smp();
    all_zero("reset");
    nxt();
    rst_n = 1'b1; start_i = 1'b0;
    nxt();

    foreach (jobs[i]) run_job(jobs[i]);

    // Start during RUN and DONE is ignored; ack in DONE loses to the set;
    // start in the first IDLE cycle after DONE is accepted.
    for (int i = 0; i < 3; i++) exp_q.push_back(i);
    start_i = 1'b1; len_i = W'(3); step_ready_i = 1'b1;
    nxt(); start_i = 1'b0;
    smp(); chk("seq_clr", cnt_clr_o, 1'b1);
    nxt(); nxt();
    start_i = 1'b1; len_i = W'(7);
    smp(); chk("run_start_ignored_idx", step_idx_o, 1);
    nxt(); start_i = 1'b0;
    smp(); chk("run_last_idx", step_idx_o, 2);
    nxt();
    start_i = 1'b1; len_i = W'(2); irq_ack_i = 1'b1;
    smp(); chk("seq_done", done_o, 1'b1);
    nxt(); irq_ack_i = 1'b0;
    for (int i = 0; i < 2; i++) exp_q.push_back(i);
    smp();
    chk("set_beats_ack", irq_o, 1'b1);
    chk("done_start_ignored", busy_o, 1'b0);
    chk("gap_no_clr", cnt_clr_o, 1'b0);
    nxt(); start_i = 1'b0;
    smp(); chk("b2b_clr", cnt_clr_o, 1'b1);
    k = 0;
    while (k < 50 && done_o !== 1'b1) begin
      nxt(); smp(); k++;
    end
    chk("b2b_done_latency", k, 3);
    nxt();

    // Reset in the middle of a len=5 job at idx 2; irq is still set here.
    for (int i = 0; i < 2; i++) exp_q.push_back(i);
    start_i = 1'b1; len_i = W'(5); step_ready_i = 1'b1;
    nxt(); start_i = 1'b0;
    nxt(); nxt(); nxt();
    step_ready_i = 1'b0;
    smp(); chk("pre_reset_idx", step_idx_o, 2);
    rst_n = 1'b0;
    nxt(); rst_n = 1'b1; step_ready_i = 1'b1;
    smp();
    all_zero("midjob_reset");
    nxt();
    run_job('{len: 1, stall_idx: 0, stall_n: 0, done_k: 3});

`ifdef MAC_SEQ_TIMEOUT_EN
    // Stall from the first step: 8 stall cycles (k=2..9), DONE at k=10.
    start_i = 1'b1; len_i = W'(2); step_ready_i = 1'b0;
    k = 0;
    while (k < 100 && done_o !== 1'b1) begin
      nxt(); start_i = 1'b0; k++; smp();
    end
    chk("timeout_done_k", k, 10);
    chk("timeout_err", err_o, 1'b1);
    nxt(); irq_ack_i = 1'b1;
    smp(); chk("timeout_irq", irq_o, 1'b1);
    nxt(); irq_ack_i = 1'b0; step_ready_i = 1'b1;
    smp();
    chk("ack_clears_err", err_o, 1'b0);
    chk("ack_clears_irq", irq_o, 1'b0);
    nxt();
`else
    // Without the watchdog a stalled job waits indefinitely.
    start_i = 1'b1; len_i = W'(2); step_ready_i = 1'b0;
    nxt(); start_i = 1'b0;
    k = 0;
    for (int i = 0; i < 300; i++) begin
      nxt(); smp();
      if (done_o === 1'b1 || busy_o !== 1'b1) k++;
    end
    chk("stall_forever", k, 0);
    chk("stall_idx0", step_idx_o, 0);
    rst_n = 1'b0;
    nxt(); rst_n = 1'b1; step_ready_i = 1'b1;
    smp();
    all_zero("stall_reset");
    nxt();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
